// File: rtl/uart_rx_if.sv
// Byte hand-off from uart_rx to its consumer: valid/ready with a one-entry holding register.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
// Delivers bytes through a one-entry holding register and pulses frame/parity/overrun errors.
module uart_rx #(
    parameter int unsigned DIVISOR = 27
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rxd,
    uart_rx_if.master rx,
    output logic      frame_err,
    output logic      overrun,
    output logic      parity_err,
    output logic      busy
);
    localparam int unsigned      DIV_W    = $clog2(DIVISOR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic             sync_1;
    logic             rxs;
    logic             rxs_d;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       sub_cnt;
    logic             tick;
    logic             sample;
    logic             start_edge;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            rxs    <= 1'b1;
            rxs_d  <= 1'b1;
        end else begin
            sync_1 <= rxd;
            rxs    <= sync_1;
            rxs_d  <= rxs;
        end
    end

    assign start_edge = (state == IDLE) && !rxs && rxs_d;
    assign tick       = (div_cnt == DIV_LAST);
    // sub_cnt==7 on a tick marks ticks 8, 24, 40, ... after start detection: bit centres
    assign sample     = tick && (sub_cnt == 4'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sub_cnt <= '0;
        end else if (start_edge) begin
            div_cnt <= '0;
            sub_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            sub_cnt <= sub_cnt + 4'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            shift       <= '0;
            bit_idx     <= '0;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A completing byte below overrides this clear, keeping valid high across the transfer
            if (rx.rx_valid && rx.rx_ready)
                rx.rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_bad <= (rxs != ^shift);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
`endif
                        end else if (rx.rx_valid && !rx.rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx.rx_data  <= shift;
                            rx.rx_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model plus per-cycle compare and pinned literal checks.
module tb_uart_rx;
    localparam int unsigned D   = 27;
    localparam int unsigned BIT = 16 * D;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PB  = 1;
    localparam int unsigned LAT = 4539;   // pin edge to rx_valid: 3 + 168*27
`else
    localparam int unsigned PB  = 0;
    localparam int unsigned LAT = 4107;   // pin edge to rx_valid: 3 + 152*27
`endif
    // two synchroniser flops plus the edge-detect register, then the stop sample tick
    localparam int unsigned STOP_CLKS = 3 + (8 + 16 * (9 + PB)) * D;

    localparam logic [12:0] M_V  = 13'h1000;
    localparam logic [12:0] M_D  = 13'h0FF0;
    localparam logic [12:0] M_FE = 13'h0008;
    localparam logic [12:0] M_OV = 13'h0004;
    localparam logic [12:0] M_PE = 13'h0002;
    localparam logic [12:0] M_BZ = 13'h0001;
    localparam logic [12:0] M_ALL = 13'h1FFF;

    typedef enum int {K_GOOD, K_FRAME, K_PAR, K_GLITCH} kind_t;
    typedef struct {
        int unsigned start;
        int unsigned at;
        kind_t       kind;
        logic [7:0]  b;
    } ev_t;
    typedef struct {
        int unsigned at;
        logic [12:0] mask;
        logic [12:0] val;
        string       name;
    } lit_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic rxd = 1'b1;
    logic frame_err, overrun, parity_err, busy;
    uart_rx_if rx_bus();

    uart_rx #(.DIVISOR(D)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd), .rx(rx_bus),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] vec(input logic v, input logic [7:0] d,
                                        input logic fe, input logic ov, input logic pe, input logic bz);
        return {v, d, fe, ov, pe, bz};
    endfunction

    // ---------------- frame-level model ----------------
    ev_t         evq[$];
    int unsigned rd = 0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic        m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0, m_busy = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        int unsigned e;
        if (!reset_n) begin
            m_valid <= 1'b0; m_data <= 8'h00;
            m_fe <= 1'b0; m_ov <= 1'b0; m_pe <= 1'b0; m_busy <= 1'b0;
            rd <= evq.size();
        end else begin
            e = cyc + 1;
            m_fe <= 1'b0; m_ov <= 1'b0; m_pe <= 1'b0;
            if (m_valid && rx_bus.rx_ready) m_valid <= 1'b0;
            if (int'(rd) < evq.size()) begin
                if (evq[rd].start == e) m_busy <= 1'b1;
                if (evq[rd].at == e) begin
                    m_busy <= 1'b0;
                    rd <= rd + 1;
                    case (evq[rd].kind)
                        K_FRAME: m_fe <= 1'b1;
                        K_PAR:   m_pe <= 1'b1;
                        K_GOOD: begin
                            if (m_valid && !rx_bus.rx_ready) m_ov <= 1'b1;
                            else begin
                                m_data  <= evq[rd].b;
                                m_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- compare process ----------------
    lit_t        litq[$];
    int unsigned lr = 0;
    logic        chk_en = 1'b0;
    int unsigned n_pass = 0, n_total = 0;

    always @(negedge clk) begin
        logic [12:0] act, want;
        int unsigned t, p, idx;
        if (chk_en) begin
            t = 0; p = 0; idx = lr;
            act  = {rx_bus.rx_valid, rx_bus.rx_data, frame_err, overrun, parity_err, busy};
            want = {m_valid, m_data, m_fe, m_ov, m_pe, m_busy};
            t++;
            if (act === want) p++;
            else $display("FAIL model_cycle %0d: {valid,data,fe,ov,pe,busy} got %h expected %h", cyc, act, want);
            while (int'(idx) < litq.size() && litq[idx].at <= cyc) begin
                t++;
                if (litq[idx].at == cyc && (act & litq[idx].mask) === litq[idx].val) p++;
                else $display("FAIL %s @%0d: got %h expected %h (mask %h)",
                              litq[idx].name, cyc, act & litq[idx].mask, litq[idx].val, litq[idx].mask);
                idx++;
            end
            lr      <= idx;
            n_total <= n_total + t;
            n_pass  <= n_pass + p;
        end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input int unsigned at, input logic [12:0] mask, input logic [12:0] val, input string nm);
        litq.push_back('{at, mask, val & mask, nm});
    endtask

    task automatic tick_to(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int unsigned k);
        tick_to(cyc + k);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        int unsigned n;
        kind_t       k;
        logic        pbit;
        n    = cyc;
        pbit = (^b) ^ par_flip;
        if (!stop_bit) k = K_FRAME;
        else if (PB == 1 && par_flip) k = K_PAR;
        else k = K_GOOD;
        evq.push_back('{n + 3, n + STOP_CLKS, k, b});
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_to(n + BIT * (i + 1));
            rxd = b[i];
        end
        if (PB == 1) begin
            tick_to(n + BIT * 9);
            rxd = pbit;
        end
        tick_to(n + BIT * (9 + PB));
        rxd = stop_bit;
        tick_to(n + BIT * (10 + PB));
    endtask

    initial begin
        int unsigned n, k;
        logic [7:0]  v;
        rx_bus.rx_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        chk_en  = 1'b1;
        lit(1, M_ALL, vec(0, 8'h00, 0, 0, 0, 0), "reset_values");
        @(posedge clk); #1;
        idle(3);
        reset_n = 1'b1;
        idle(20);

        // single byte, latency and one-cycle valid pulse
        n = cyc;
        lit(n + 2,       M_BZ, 13'h0000, "t1_idle_before_detect");
        lit(n + 3,       M_BZ, M_BZ, "t1_busy_after_detect");
        lit(n + LAT - 1, M_V | M_BZ, M_BZ, "t1_not_early");
        lit(n + LAT,     M_ALL, vec(1, 8'h55, 0, 0, 0, 0), "t1_byte55");
        lit(n + LAT + 1, M_V, 13'h0000, "t1_one_cycle");
        send_frame(8'h55, 1'b1, 1'b0);
        idle(100);

        // back-to-back frames
        n = cyc;
        lit(n + LAT, M_V | M_D, vec(1, 8'hA5, 0, 0, 0, 0), "t2_first_A5");
        lit(n + BIT * (10 + PB) + LAT, M_V | M_D, vec(1, 8'h3C, 0, 0, 0, 0), "t2_second_3C");
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(100);

        // 4-tick glitch rejected at the start sample
        n = cyc;
        evq.push_back('{n + 3, n + 3 + 8 * D, K_GLITCH, 8'h00});
        lit(n + 2 + 8 * D, M_BZ, M_BZ, "t3_busy_until_sample");
        lit(n + 3 + 8 * D, M_V | M_FE | M_BZ, 13'h0000, "t3_glitch_idle");
        rxd = 1'b0;
        tick_to(n + 4 * D);
        rxd = 1'b1;
        tick_to(n + BIT * 2);

        // zero stop bit, then break held low, then a good frame
        n = cyc;
        lit(n + LAT, M_V | M_FE | M_OV | M_PE | M_BZ, vec(0, 8'h00, 1, 0, 0, 0), "t4_frame_err");
        send_frame(8'hFF, 1'b0, 1'b0);
        idle(2 * BIT);
        rxd = 1'b1;
        idle(BIT);
        n = cyc;
        lit(n + LAT, M_V | M_D | M_FE, vec(1, 8'h12, 0, 0, 0, 0), "t4_after_break_12");
        send_frame(8'h12, 1'b1, 1'b0);
        idle(100);

        // overrun with consumer stalled
        rx_bus.rx_ready = 1'b0;
        n = cyc;
        lit(n + LAT, M_V | M_D, vec(1, 8'h11, 0, 0, 0, 0), "t5_hold_11");
        lit(n + BIT * (10 + PB) + LAT, M_V | M_D | M_OV | M_FE, vec(1, 8'h11, 0, 1, 0, 0), "t5_overrun");
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(50);
        k = cyc;
        lit(k,     M_V | M_D, vec(1, 8'h11, 0, 0, 0, 0), "t5_still_held");
        lit(k + 1, M_V | M_D, vec(0, 8'h11, 0, 0, 0, 0), "t5_transfer_clears");
        rx_bus.rx_ready = 1'b1;
        idle(100);

        // reset in the middle of data bit 4 of 0x5A
        v = 8'h5A;
        n = cyc;
        evq.push_back('{n + 3, 32'hFFFF_FFFF, K_GLITCH, 8'h00});
        rxd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_to(n + BIT * (i + 1));
            rxd = v[i];
        end
        tick_to(n + BIT * 5 + BIT / 2);
        lit(cyc, M_ALL, vec(0, 8'h00, 0, 0, 0, 0), "t6_reset_midframe");
        reset_n = 1'b0;
        rxd = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(BIT);
        n = cyc;
        lit(n + LAT, M_V | M_D, vec(1, 8'h5A, 0, 0, 0, 0), "t6_after_reset_5A");
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(100);

`ifdef UART_RX_PARITY_EN
        n = cyc;
        lit(n + LAT, M_V | M_PE | M_FE | M_OV, vec(0, 8'h00, 0, 0, 1, 0), "t7_parity_err");
        send_frame(8'h01, 1'b1, 1'b1);
        idle(100);
        n = cyc;
        lit(n + LAT, M_V | M_D | M_PE, vec(1, 8'h03, 0, 0, 0, 0), "t7_parity_good_03");
        send_frame(8'h03, 1'b1, 1'b0);
        idle(100);
`endif

        idle(50);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
